// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and data bundle between ID stage, FPU execute and FP writeback
// as seen by the issue/retire controller.
interface fpu_issue_ctrl_if;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_fpusel;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic [31:0] id_c;
    logic [4:0]  id_rd;

    logic        fu_start;
    logic [4:0]  fu_op;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic [31:0] fu_c;
    logic        fu_done;
    logic [31:0] fu_res;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;
    logic        wb_timeout;
    logic        stall;

    // Controller side
    modport slave (
        input  id_valid, id_fpusel, id_a, id_b, id_c, id_rd, fu_done, fu_res,
        output id_ready, fu_start, fu_op, fu_a, fu_b, fu_c,
               wb_valid, wb_rd, wb_data, wb_illegal, wb_timeout, stall
    );

    // Environment side: ID stage, FPU and writeback together
    modport master (
        output id_valid, id_fpusel, id_a, id_b, id_c, id_rd, fu_done, fu_res,
        input  id_ready, fu_start, fu_op, fu_a, fu_b, fu_c,
               wb_valid, wb_rd, wb_data, wb_illegal, wb_timeout, stall
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue/retire controller: accepts one op, pulses the FPU, waits for the
// result (or a timeout) and emits a single writeback beat.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              g_clk,
    input  logic              g_rst,
    fpu_issue_ctrl_if.slave   bus
);
    localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;
    localparam logic [8:0]  TIMEOUT_W = 9'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  op_reg;
    logic [31:0] a_reg, b_reg, c_reg;
    logic [4:0]  rd_reg;
    logic [31:0] res_reg;
    logic        illegal_reg, timeout_reg;
    logic [7:0]  cnt_reg, cnt_next;

    logic is_multi, is_single, is_illegal, timeout_hit;

    assign is_multi   = (op_reg <= 5'd3) || ((op_reg >= 5'd20) && (op_reg <= 5'd23));
    assign is_single  = (op_reg >= 5'd5) && (op_reg <= 5'd15);
    assign is_illegal = !is_multi && !is_single;

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; counter holds at the limit.
    assign timeout_hit = ({1'b0, cnt_reg} + 9'd1) >= TIMEOUT_W;
    assign cnt_next    = ({1'b0, cnt_reg} >= TIMEOUT_W) ? cnt_reg : cnt_reg + 8'd1;

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.id_valid) state_next = S_ISSUE;
            S_ISSUE: begin
                if (is_illegal || is_single || bus.fu_done) state_next = S_WB;
                else                                        state_next = S_WAIT;
            end
            S_WAIT:  if (bus.fu_done || timeout_hit) state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            rd_reg      <= '0;
            res_reg     <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.id_valid) begin
                        op_reg <= bus.id_fpusel;
                        a_reg  <= bus.id_a;
                        b_reg  <= bus.id_b;
                        c_reg  <= bus.id_c;
                        rd_reg <= bus.id_rd;
                    end
                end
                S_ISSUE: begin
                    if (is_illegal) begin
                        res_reg     <= CANON_NAN;
                        illegal_reg <= 1'b1;
                    end else if (is_single || bus.fu_done) begin
                        res_reg <= bus.fu_res;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_next;
                    // A result strobe in the timeout cycle still counts as success.
                    if (bus.fu_done) begin
                        res_reg <= bus.fu_res;
                    end else if (timeout_hit) begin
                        res_reg     <= CANON_NAN;
                        timeout_reg <= 1'b1;
                    end
                end
                S_WB: begin
                    cnt_reg     <= '0;
                    illegal_reg <= 1'b0;
                    timeout_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.id_ready   = (state_reg == S_IDLE);
        bus.stall      = (state_reg != S_IDLE);
        bus.fu_start   = (state_reg == S_ISSUE) && !is_illegal;
        bus.fu_op      = op_reg;
        bus.fu_a       = a_reg;
        bus.fu_b       = b_reg;
        bus.fu_c       = c_reg;
        bus.wb_valid   = (state_reg == S_WB);
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
        bus.wb_illegal = 1'b0;
        bus.wb_timeout = 1'b0;
        if (state_reg == S_WB) begin
            bus.wb_rd      = rd_reg;
            bus.wb_data    = res_reg;
            bus.wb_illegal = illegal_reg;
            bus.wb_timeout = timeout_reg;
        end
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue/retire controller between the ID stage and the FPU execute block. It accepts one decoded floating-point operation at a time and registers the operands. It launches the selected unit with a one-cycle start pulse, then waits for the unit's result strobe, with a fixed latency for single-cycle ops and a timeout for multi-cycle ops. It presents the result to FP writeback as a one-cycle valid beat and holds the pipeline stall asserted while an operation is in flight.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: maximum number of WAIT cycles before a multi-cycle op is aborted. Legal range 1..255.

Ports:
- g_clk  in  1  global clock; all state updates on the rising edge
- g_rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage presents an FP op
- id_ready  out  1  controller can accept; high only in IDLE
- id_fpusel  in  5  op select: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5–15 single-cycle (sgnj/min/max/cmp/mv/class), 16–19 FMA, 20–23 cvt
- id_a, id_b, id_c  in  32 each  operands
- id_rd  in  5  destination register index
- fu_start  out  1  one-cycle launch pulse to the FPU
- fu_op  out  5  registered op select, held from ISSUE through WB
- fu_a, fu_b, fu_c  out  32 each  registered operands, held from ISSUE through WB
- fu_done  in  1  unit result strobe (multi-cycle class)
- fu_res  in  32  unit result
- wb_valid  out  1  one-cycle writeback beat
- wb_rd  out  5  destination register
- wb_data  out  32  result
- wb_illegal  out  1  op unsupported; wb_data is canonical NaN
- wb_timeout  out  1  op aborted by timeout; wb_data is canonical NaN
- stall  out  1  pipeline stall; high whenever state is not IDLE

## Operation
Op classes:
- Multi-cycle: 0–3 and 20–23.
- Single-cycle: 5–15.
- Illegal: 4, 16–19 and 24–31.

FSM states:
- IDLE: id_ready=1. On id_valid, register id_fpusel, operands and id_rd, then go to ISSUE.
- ISSUE: one cycle.
  - Multi-cycle: fu_start=1. If fu_done=1 in this cycle, capture fu_res and go to WB; otherwise go to WAIT.
  - Single-cycle: fu_start=1, capture fu_res at the end of this cycle, go to WB.
  - Illegal: fu_start=0, wb_data=32'h7fc00000, illegal flag set, go to WB.
- WAIT: the cycle counter increments each cycle.
  - fu_done=1: capture fu_res, go to WB.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES: load NaN, set the timeout flag, go to WB.
  - If fu_done and the timeout occur in the same cycle, fu_done wins.
- WB: wb_valid=1 for exactly one cycle, then go to IDLE. The counter and flags clear on entry to IDLE.

Rules:
- fu_done is ignored in IDLE and WB.
- Operands are passed through unmodified; sub negation is the FPU's responsibility.
- The counter width is 8 bits and it never wraps: it saturates at TIMEOUT_CYCLES.
- wb_rd, wb_data, wb_illegal and wb_timeout are valid only when wb_valid=1; they read 0 otherwise.

## Timing
Reset:
- g_rst high at a rising edge forces IDLE.
- All outputs read 0 after reset, except id_ready=1: fu_start, fu_op, fu_a/b/c, wb_*, and stall=0.

Reset mid-operation:
- Reset during ISSUE, WAIT or WB aborts the operation with no wb_valid.
- A late fu_done arriving after reset is ignored.

Latency, for an op accepted at edge N (id_valid && id_ready sampled at N):
- Single-cycle or illegal: ISSUE in cycle N+1, wb_valid in cycle N+2.
- Multi-cycle with fu_done first high in cycle M ≥ N+1: wb_valid in cycle M+1.
- Timeout: wb_valid in cycle N+2+TIMEOUT_CYCLES.

Throughput and stall:
- The next accept is possible at the edge following the WB cycle.
- stall rises in the cycle after accept and falls in the cycle after WB.

## Test plan
- Reset, then single-cycle op 5 (fsgnj), a=0x3f800000, b=0xbf800000, fu_res=0xbf800000 -> fu_start in N+1; wb_valid in N+2 with wb_data=0xbf800000, wb_rd echoed, stall high for exactly 2 cycles.
- Add op (0), fu_done asserted 5 cycles after fu_start with fu_res=0x40400000 -> wb_valid exactly 1 cycle after fu_done, data 0x40400000; id_ready low throughout; fu_a/b held stable.
- Op 17 (FMA) -> no fu_start; wb_valid in N+2 with wb_data=0x7fc00000, wb_illegal=1.
- Div op (3), TIMEOUT_CYCLES=8, fu_done never asserted -> wb_valid in N+10 with wb_data=0x7fc00000, wb_timeout=1. Repeat with fu_done asserted in the 8th WAIT cycle -> normal result, wb_timeout=0.
- Reset asserted in the 3rd WAIT cycle of a mul, then fu_done pulsed next cycle -> no wb_valid; id_ready=1 and stall=0 after reset; next op issues normally.
- Back-to-back id_valid held high with two cvt ops (20, 22) -> second accepted only after the first's WB cycle; two distinct wb_valid beats in order; fu_done pulse in IDLE produces no beat.
